// File: rtl/bht_port_ctrl_pkg.sv
// Shared types and constants for the branch-history-table port controller:
// FSM state encoding, 2-bit counter limits and the queued update record.
package bht_port_ctrl_pkg;

    localparam int BHT_DATAWIDTH = 64;
    localparam int BHT_INDEXSIZE = 256;
    localparam int BHT_LOGINDEX  = 8;
    localparam int BHT_LOGSLOT   = 5;
    localparam int BHT_QDEPTH    = 4;
    localparam int BHT_LOGQ      = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    localparam logic [1:0] CTR_MAX = 2'd3;
    localparam logic [1:0] CTR_MIN = 2'd0;

    // One pending counter update as it sits in the queue.
    typedef struct packed {
        logic [BHT_LOGINDEX-1:0] index;
        logic [BHT_LOGSLOT-1:0]  slot;
        logic                    taken;
    } upd_rec_t;

    // Saturating 2-bit counter step: taken counts up to CTR_MAX, not-taken down to CTR_MIN.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_MAX) ? CTR_MAX : ctr + 2'd1;
        end
        return (ctr == CTR_MIN) ? CTR_MIN : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/bht_port_ctrl_if.sv
// Bundle of the controller's request, status and RAM-port signals.
// slave = controller view, master = fetch/retire/RAM environment view.
interface bht_port_ctrl_if #(
    parameter int DATAWIDTH = 64,
    parameter int LOGINDEX  = 8,
    parameter int LOGSLOT   = 5
);
    logic                 flush_in;
    logic                 lookup_valid_in;
    logic [LOGINDEX-1:0]  lookup_index_in;
    logic                 lookup_ready_out;
    logic [DATAWIDTH-1:0] lookup_data_out;
    logic                 upd_valid_in;
    logic [LOGINDEX-1:0]  upd_index_in;
    logic [LOGSLOT-1:0]   upd_slot_in;
    logic                 upd_taken_in;
    logic                 upd_ready_out;
    logic                 busy_out;
    logic                 ram_we_out;
    logic [LOGINDEX-1:0]  ram_index_out;
    logic [DATAWIDTH-1:0] ram_data_out;
    logic [DATAWIDTH-1:0] ram_data_in;

    modport slave (
        input  flush_in, lookup_valid_in, lookup_index_in,
        input  upd_valid_in, upd_index_in, upd_slot_in, upd_taken_in,
        input  ram_data_in,
        output lookup_ready_out, lookup_data_out, upd_ready_out, busy_out,
        output ram_we_out, ram_index_out, ram_data_out
    );

    modport master (
        output flush_in, lookup_valid_in, lookup_index_in,
        output upd_valid_in, upd_index_in, upd_slot_in, upd_taken_in,
        output ram_data_in,
        input  lookup_ready_out, lookup_data_out, upd_ready_out, busy_out,
        input  ram_we_out, ram_index_out, ram_data_out
    );
endinterface

// File: rtl/bht_port_ctrl_upd_fifo.sv
// Synchronous FIFO holding pending counter updates.
// Head word is visible combinationally on dout_o; clear_i empties it in one cycle
// and takes priority over push/pop. Push when full and pop when empty are ignored.
module upd_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4,
    parameter int LOGD  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [LOGD-1:0] PTR_ONE = LOGD'(1);
    localparam logic [LOGD:0]   CNT_ONE = (LOGD + 1)'(1);
    localparam logic [LOGD:0]   CNT_MAX = (LOGD + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LOGD-1:0]  wr_ptr_q;
    logic [LOGD-1:0]  rd_ptr_q;
    logic [LOGD:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_MAX);
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    // Storage write on an accepted push.
    // NOTE: the storage array has no reset; count_q alone decides which words are live.
    // NOTE: sequential state uses <= so every register samples its pre-edge value.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointer and occupancy bookkeeping; clear wins over push/pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/bht_port_ctrl.sv
// Port controller for the single-port branch counter table.
// Arbitrates fetch lookups against queued counter updates (one RAM access per cycle),
// performs each update as a single-cycle read-modify-write, and runs a sequential
// flush engine that rewrites every entry with INITVALUE.
module bht_port_ctrl
    import bht_port_ctrl_pkg::*;
#(
    parameter int                   DATAWIDTH = BHT_DATAWIDTH,
    parameter int                   INDEXSIZE = BHT_INDEXSIZE,
    parameter int                   LOGINDEX  = BHT_LOGINDEX,
    parameter int                   LOGSLOT   = BHT_LOGSLOT,
    parameter logic [DATAWIDTH-1:0] INITVALUE = '0,
    parameter int                   QDEPTH    = BHT_QDEPTH,
    parameter int                   LOGQ      = BHT_LOGQ
) (
    input logic            clk,
    input logic            reset,
    bht_port_ctrl_if.slave bus
);

    localparam int REC_W = $bits(upd_rec_t);

    // One extra counter bit keeps the last-entry compare unambiguous.
    localparam logic [LOGINDEX:0] CNT_LAST = (LOGINDEX + 1)'(INDEXSIZE - 1);
    localparam logic [LOGINDEX:0] CNT_ONE  = (LOGINDEX + 1)'(1);

    state_e               state_q;
    logic [LOGINDEX:0]    flush_cnt_q;
    logic [LOGINDEX-1:0]  ram_index_q;
    logic [LOGINDEX-1:0]  ram_index_d;

    logic                 sel_flush;
    logic                 sel_pop;
    logic                 sel_lookup;
    logic                 upd_ready;

    logic                 fifo_push;
    logic                 fifo_clear;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [REC_W-1:0]     fifo_dout;
    upd_rec_t             head;
    upd_rec_t             new_rec;
    logic [LOGSLOT-1:0]   head_slot;
    logic [DATAWIDTH-1:0] rmw_data;

    assign new_rec   = '{index: bus.upd_index_in, slot: bus.upd_slot_in, taken: bus.upd_taken_in};
    assign head      = upd_rec_t'(fifo_dout);
    assign head_slot = head.slot;

    assign fifo_push  = upd_ready && bus.upd_valid_in;
    assign fifo_clear = (state_q == ST_IDLE) && bus.flush_in;

    upd_fifo #(
        .WIDTH (REC_W),
        .DEPTH (QDEPTH),
        .LOGD  (LOGQ)
    ) u_upd_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .din_i   (REC_W'(new_rec)),
        .pop_i   (sel_pop),
        .clear_i (fifo_clear),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Flush FSM: IDLE <-> FLUSH, walking the counter over every table entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.flush_in) begin
                        state_q     <= ST_FLUSH;
                        flush_cnt_q <= '0;
                    end
                end
                ST_FLUSH: begin
                    if (bus.flush_in) begin
                        flush_cnt_q <= '0;
                    end else if (flush_cnt_q == CNT_LAST) begin
                        state_q     <= ST_IDLE;
                        flush_cnt_q <= '0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    flush_cnt_q <= '0;
                end
            endcase
        end
    end

    // Remember the last driven RAM index so an idle cycle keeps it stable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_index_q <= '0;
        end else begin
            ram_index_q <= ram_index_d;
        end
    end

    // Port arbitration: full queue, then lookup, then a pending update.
    // NOTE: every signal gets a default first so no latch is inferred.
    always_comb begin
        sel_flush   = 1'b0;
        sel_pop     = 1'b0;
        sel_lookup  = 1'b0;
        upd_ready   = 1'b0;
        ram_index_d = ram_index_q;
        if (reset) begin
            ram_index_d = '0;
        end else if (state_q == ST_FLUSH) begin
            sel_flush   = 1'b1;
            ram_index_d = flush_cnt_q[LOGINDEX-1:0];
        end else begin
            upd_ready = !fifo_full;
            if (fifo_full || (!bus.lookup_valid_in && !fifo_empty)) begin
                sel_pop     = 1'b1;
                ram_index_d = head.index;
            end else if (bus.lookup_valid_in) begin
                sel_lookup  = 1'b1;
                ram_index_d = bus.lookup_index_in;
            end
        end
    end

    // Read-modify-write: replace only the addressed 2-bit counter of the entry.
    always_comb begin
        rmw_data = bus.ram_data_in;
        rmw_data[{head_slot, 1'b0} +: 2] =
            ctr_step(bus.ram_data_in[{head_slot, 1'b0} +: 2], head.taken);
    end

    assign bus.ram_index_out    = ram_index_d;
    assign bus.ram_we_out       = sel_flush | sel_pop;
    assign bus.ram_data_out     = sel_flush ? INITVALUE : (sel_pop ? rmw_data : '0);
    assign bus.lookup_ready_out = sel_lookup;
    assign bus.lookup_data_out  = sel_lookup ? bus.ram_data_in : '0;
    assign bus.upd_ready_out    = upd_ready;
    assign bus.busy_out         = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_bht_port_ctrl.sv
// Self-checking bench for bht_port_ctrl: directed scenarios plus randomized traffic,
// compared cycle by cycle against a counter-level reference model of the table.
module tb_bht_port_ctrl;

    localparam int DW    = 64;
    localparam int NIDX  = 256;
    localparam int LI    = 8;
    localparam int LS    = 5;
    localparam int QD    = 4;
    localparam int NSLOT = DW / 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bht_port_ctrl_if #(.DATAWIDTH(DW), .LOGINDEX(LI), .LOGSLOT(LS)) bus ();

    bht_port_ctrl #(
        .DATAWIDTH (DW),
        .INDEXSIZE (NIDX),
        .LOGINDEX  (LI),
        .LOGSLOT   (LS),
        .INITVALUE (64'h0),
        .QDEPTH    (QD),
        .LOGQ      (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Table RAM: combinational read, synchronous write.
    logic [DW-1:0] ram [NIDX] = '{default: '0};
    assign bus.ram_data_in = ram[bus.ram_index_out];
    always @(posedge clk) begin
        if (bus.ram_we_out) ram[bus.ram_index_out] <= bus.ram_data_out;
    end

    // Reference model: counters as integers, pending updates as a queue.
    typedef struct {
        int idx;
        int slot;
        bit taken;
    } upd_t;

    upd_t m_q[$];
    int   m_ctr [NIDX][NSLOT];
    bit   m_flush;
    int   m_cnt;
    int   m_last_idx;

    int   checks = 0;
    int   errors = 0;

    logic          obs_busy, obs_lr, obs_ur, obs_we;
    logic [DW-1:0] obs_ld;
    int            obs_idx;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pack_entry(input int idx);
        logic [DW-1:0] e = '0;
        for (int s = 0; s < NSLOT; s++) e[2*s +: 2] = 2'(m_ctr[idx][s]);
        return e;
    endfunction

    task automatic model_reset();
        m_flush    = 1'b0;
        m_cnt      = 0;
        m_last_idx = 0;
        m_q.delete();
    endtask

    // Every output must read 0 while reset is asserted.
    task automatic check_all_zero(input string tag);
        check({tag, "_lookup_ready"}, 64'(bus.lookup_ready_out), 64'h0);
        check({tag, "_lookup_data"},  64'(bus.lookup_data_out),  64'h0);
        check({tag, "_upd_ready"},    64'(bus.upd_ready_out),    64'h0);
        check({tag, "_busy"},         64'(bus.busy_out),         64'h0);
        check({tag, "_ram_we"},       64'(bus.ram_we_out),       64'h0);
        check({tag, "_ram_index"},    64'(bus.ram_index_out),    64'h0);
        check({tag, "_ram_data"},     64'(bus.ram_data_out),     64'h0);
    endtask

    // One clock cycle: drive at the falling edge, compare 1 time unit later, advance the model.
    task automatic step(input int fl, input int lv, input int li,
                        input int uv, input int ui, input int us, input int ut);
        bit            e_we, e_lr, e_ur, e_busy, do_pop;
        int            e_idx, c;
        logic [DW-1:0] e_wd, e_ld;
        upd_t          u;

        bus.flush_in        = (fl != 0);
        bus.lookup_valid_in = (lv != 0);
        bus.lookup_index_in = LI'(li);
        bus.upd_valid_in    = (uv != 0);
        bus.upd_index_in    = LI'(ui);
        bus.upd_slot_in     = LS'(us);
        bus.upd_taken_in    = (ut != 0);
        #1;

        e_we   = 1'b0;
        e_lr   = 1'b0;
        e_wd   = '0;
        e_ld   = '0;
        e_idx  = m_last_idx;
        do_pop = 1'b0;
        e_busy = m_flush;
        e_ur   = !m_flush && (m_q.size() < QD);

        if (m_flush) begin
            e_we  = 1'b1;
            e_idx = m_cnt;
            for (int s = 0; s < NSLOT; s++) m_ctr[m_cnt][s] = 0;
            e_wd  = 64'h0;
        end else if (m_q.size() == QD || (lv == 0 && m_q.size() != 0)) begin
            u      = m_q[0];
            do_pop = 1'b1;
            e_we   = 1'b1;
            e_idx  = u.idx;
            c      = m_ctr[u.idx][u.slot];
            if (u.taken) c = (c < 3) ? c + 1 : 3;
            else         c = (c > 0) ? c - 1 : 0;
            m_ctr[u.idx][u.slot] = c;
            e_wd   = pack_entry(u.idx);
        end else if (lv != 0) begin
            e_lr  = 1'b1;
            e_idx = li;
            e_ld  = pack_entry(li);
        end

        obs_busy = bus.busy_out;
        obs_lr   = bus.lookup_ready_out;
        obs_ur   = bus.upd_ready_out;
        obs_we   = bus.ram_we_out;
        obs_ld   = bus.lookup_data_out;
        obs_idx  = int'(bus.ram_index_out);

        check("lookup_ready", 64'(obs_lr),   64'(e_lr));
        check("upd_ready",    64'(obs_ur),   64'(e_ur));
        check("busy",         64'(obs_busy), 64'(e_busy));
        check("ram_we",       64'(obs_we),   64'(e_we));
        check("ram_index",    64'(obs_idx),  64'(e_idx));
        if (e_we) check("ram_wdata",   64'(bus.ram_data_out), 64'(e_wd));
        if (e_lr) check("lookup_data", 64'(obs_ld),           64'(e_ld));

        if (m_flush) begin
            if (fl != 0)               m_cnt = 0;
            else if (m_cnt == NIDX - 1) begin m_flush = 1'b0; m_cnt = 0; end
            else                       m_cnt++;
        end else begin
            if (do_pop) void'(m_q.pop_front());
            if (uv != 0 && e_ur) m_q.push_back('{idx: ui, slot: us, taken: (ut != 0)});
            if (fl != 0) begin
                m_flush = 1'b1;
                m_cnt   = 0;
                m_q.delete();
            end
        end
        m_last_idx = e_idx;

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        int busy_cycles;

        // Reset: outputs zero while asserted, even with requests pending.
        reset               = 1'b1;
        bus.flush_in        = 1'b0;
        bus.lookup_valid_in = 1'b1;
        bus.lookup_index_in = 8'd5;
        bus.upd_valid_in    = 1'b1;
        bus.upd_index_in    = 8'd1;
        bus.upd_slot_in     = 5'd0;
        bus.upd_taken_in    = 1'b1;
        model_reset();
        #3;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // 1: lookup after reset is accepted in the same cycle and reads 0.
        step(0, 1, 5, 0, 0, 0, 0);
        check("t1_lookup_ready", 64'(obs_lr), 64'h1);
        check("t1_lookup_data",  64'(obs_ld), 64'h0);

        // 2: repeated taken updates to entry 3 slot 0 saturate at 3.
        for (int k = 1; k <= 4; k++) begin
            step(0, 0, 0, 1, 3, 0, 1);
            idle();
            step(0, 1, 3, 0, 0, 0, 0);
            check($sformatf("t2_entry3_after_%0d", k), 64'(obs_ld), 64'((k < 3) ? k : 3));
        end

        // 3: fill the queue under continuous lookups; a full queue forces a pop.
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 2, 1, $urandom_range(4, 7), $urandom_range(0, 31), $urandom_range(0, 1));
            check($sformatf("t3_push_ready_%0d", k), 64'(obs_ur), 64'h1);
        end
        step(0, 1, 2, 1, 6, 1, 1);
        check("t3_full_lookup_ready", 64'(obs_lr), 64'h0);
        check("t3_full_pop_we",       64'(obs_we), 64'h1);
        check("t3_full_upd_ready",    64'(obs_ur), 64'h0);
        step(0, 1, 2, 1, 6, 1, 1);
        check("t3_after_pop_lookup",  64'(obs_lr), 64'h1);
        step(0, 1, 2, 1, 6, 1, 1);
        check("t3_full_again_ready",  64'(obs_ur), 64'h0);
        for (int k = 0; k < 6; k++) idle();

        // 4: flush with updates queued; they are discarded and the table is cleared.
        step(0, 1, 0, 1, 3, 1, 1);
        step(0, 1, 0, 1, 9, 4, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        busy_cycles = 0;
        for (int i = 0; i < 600; i++) begin
            idle();
            if (obs_busy) busy_cycles++;
            else break;
        end
        check("t4_flush_busy_cycles", 64'(busy_cycles), 64'd256);
        step(0, 1, 3, 0, 0, 0, 0);
        check("t4_entry3_after_flush", 64'(obs_ld), 64'h0);

        // 5: restarting a flush at index 100 goes back to index 0.
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300 && m_cnt != 100; i++) idle();
        step(1, 0, 0, 0, 0, 0, 0);
        busy_cycles = 0;
        for (int i = 0; i < 600; i++) begin
            idle();
            if (i == 0) check("t5_restart_index", 64'(obs_idx), 64'h0);
            if (obs_busy) busy_cycles++;
            else break;
        end
        check("t5_restart_busy_cycles", 64'(busy_cycles), 64'd256);

        // 6: reset in the middle of a flush.
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300 && m_cnt != 40; i++) idle();
        #2;
        reset               = 1'b1;
        bus.lookup_valid_in = 1'b1;
        bus.upd_valid_in    = 1'b1;
        #1;
        check_all_zero("t6_reset_mid_flush");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_all_zero("t6_reset_held");
        reset = 1'b0;
        step(0, 1, 77, 0, 0, 0, 0);
        check("t6_lookup_after_release", 64'(obs_lr), 64'h1);

        // Randomized traffic with occasional flushes.
        for (int n = 0; n < 1500; n++) begin
            step(($urandom_range(0, 699) == 0) ? 1 : 0,
                 $urandom_range(0, 1),
                 $urandom_range(0, 15),
                 ($urandom_range(0, 9) < 6) ? 1 : 0,
                 $urandom_range(0, 7),
                 ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 31),
                 $urandom_range(0, 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
